// File: rtl/lane_rr_scheduler_if.sv
// Lane-side request/data bus plus the shared downstream channel of the round-robin lane scheduler.
interface lane_rr_scheduler_if #(
    parameter int P  = 4,
    parameter int DW = 8
);
    localparam int SW = (P > 1) ? $clog2(P) : 1;

    logic [P-1:0]    req_i;
    logic [P-1:0]    last_i;
    logic [P*DW-1:0] data_i;
    logic [P-1:0]    ack_o;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [DW-1:0]   out_data_o;
    logic [SW-1:0]   out_src_o;
    logic            out_last_o;
    logic            busy_o;

    modport slave (
        input  req_i, last_i, data_i, out_ready_i,
        output ack_o, out_valid_o, out_data_o, out_src_o, out_last_o, busy_o
    );

    modport master (
        output req_i, last_i, data_i, out_ready_i,
        input  ack_o, out_valid_o, out_data_o, out_src_o, out_last_o, busy_o
    );
endinterface

// File: rtl/lane_rr_scheduler.sv
// Round-robin burst scheduler: request -> grant one cycle later, one IDLE bubble after each release.
// Backpressure: out_ready_i low holds the grant and data; ack_o follows out_ready_i combinationally.
module lane_rr_scheduler #(
    parameter int P         = 4,
    parameter int DW        = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    lane_rr_scheduler_if.slave   bus
);
    localparam int SW = (P > 1) ? $clog2(P) : 1;
    localparam int BW = $clog2(MAX_BEATS + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        r_state;
    logic [SW-1:0] r_sel;
    logic [SW-1:0] r_ptr;
    logic [BW-1:0] r_beats;

    logic          w_busy;
    logic          w_valid;
    logic          w_xfer;
    logic          w_last;
    logic          w_any_req;
    logic          w_hit_hi;
    logic [SW-1:0] w_pick_hi;
    logic [SW-1:0] w_pick_any;
    logic [SW-1:0] w_pick;
    logic [P-1:0]  w_gnt;
    logic [P-1:0]  w_ack;
    logic [P-1:0]  w_lane_vld;
    logic [P-1:0]  w_lane_lst;
    logic [DW-1:0] w_lane_dat [P];
    logic [DW-1:0] w_dat;

    assign w_busy = (r_state == BUSY);

    genvar k;
    generate
        for (k = 0; k < P; k++) begin : g_lane
            assign w_gnt[k]      = w_busy && (r_sel == SW'(k));
            assign w_ack[k]      = w_gnt[k] & w_xfer;
            assign w_lane_vld[k] = w_gnt[k] & bus.req_i[k];
            assign w_lane_lst[k] = w_gnt[k] & bus.last_i[k];
            assign w_lane_dat[k] = w_gnt[k] ? bus.data_i[k*DW +: DW] : '0;
        end
    endgenerate

    always_comb begin
        w_dat = '0;
        for (int i = 0; i < P; i++) begin
            w_dat = w_dat | w_lane_dat[i];
        end
    end

    assign w_valid = |w_lane_vld;
    assign w_last  = w_valid & ((|w_lane_lst) | (r_beats == BW'(MAX_BEATS - 1)));
    assign w_xfer  = w_valid & bus.out_ready_i;

    // Rotating priority: lowest requester at or above ptr, else lowest overall (wrap).
    always_comb begin
        w_hit_hi   = 1'b0;
        w_pick_hi  = '0;
        w_pick_any = '0;
        for (int j = P - 1; j >= 0; j--) begin
            if (bus.req_i[j]) begin
                w_pick_any = SW'(j);
            end
            if (bus.req_i[j] && (SW'(j) >= r_ptr)) begin
                w_hit_hi  = 1'b1;
                w_pick_hi = SW'(j);
            end
        end
        w_pick = w_hit_hi ? w_pick_hi : w_pick_any;
    end

    assign w_any_req = |bus.req_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_beats <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_sel   <= w_pick;
                        r_state <= BUSY;
                        r_beats <= '0;
                    end
                end
                BUSY: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_state <= IDLE;
                            r_ptr   <= (r_sel == SW'(P - 1)) ? '0 : r_sel + 1'b1;
                            r_beats <= '0;
                        end else begin
                            r_beats <= r_beats + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ack_o       = w_ack;
    assign bus.out_valid_o = w_valid;
    assign bus.out_data_o  = w_dat;
    assign bus.out_src_o   = w_busy ? r_sel : '0;
    assign bus.out_last_o  = w_last;
    assign bus.busy_o      = w_busy;
endmodule

// File: tb/tb_lane_rr_scheduler.sv
// Self-checking bench: lane queues feed the scheduler, a scoreboard checks every transfer, vectors check per-cycle outputs.
module tb_lane_rr_scheduler;
    localparam int P  = 4;
    localparam int DW = 8;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          lst;
    } word_t;

    typedef struct packed {
        logic [1:0]    src;
        logic [DW-1:0] dat;
        logic          lst;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       rdy;
        int         load;
        logic       en;
        logic       busy;
        logic       vld;
        logic [1:0] src;
        logic [3:0] ack;
        logic       lst;
        logic [7:0] dat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lane_rr_scheduler_if #(.P(P), .DW(DW)) bus  ();
    lane_rr_scheduler_if #(.P(P), .DW(DW)) bus3 ();

    lane_rr_scheduler #(.P(P), .DW(DW), .MAX_BEATS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    lane_rr_scheduler #(.P(P), .DW(DW), .MAX_BEATS(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    word_t      lane_q [P][$];
    exp_t       exp_q [$];
    int         xfer_cyc [$];
    int         xfer_cnt = 0;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic       rst_ctl = 1'b1;
    logic       rdy_ctl = 1'b1;
    logic [P-1:0] hold_ctl = '0;
    vec_t       tbl [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Lane models: present the head word of each queue, all inputs change just after the rising edge.
    initial begin : bfm
        rst             = 1'b1;
        bus.req_i       = '0;
        bus.last_i      = '0;
        bus.data_i      = '0;
        bus.out_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rst             = rst_ctl;
            bus.out_ready_i = rdy_ctl;
            for (int k = 0; k < P; k++) begin
                if (lane_q[k].size() > 0) bus.data_i[k*DW +: DW] = lane_q[k][0].dat;
                else                      bus.data_i[k*DW +: DW] = 8'hEE;
                if (lane_q[k].size() > 0 && !hold_ctl[k]) begin
                    bus.req_i[k]  = 1'b1;
                    bus.last_i[k] = lane_q[k][0].lst;
                end else begin
                    bus.req_i[k]  = 1'b0;
                    bus.last_i[k] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            for (int k = 0; k < P; k++) begin
                if (bus.ack_o[k] && lane_q[k].size() > 0) void'(lane_q[k].pop_front());
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb_unexpected: got src=%0d dat=%h last=%b, required no transfer",
                             bus.out_src_o, bus.out_data_o, bus.out_last_o);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_src_o !== e.src || bus.out_data_o !== e.dat || bus.out_last_o !== e.lst) begin
                        n_errors++;
                        $display("FAIL sb_xfer: got src=%0d dat=%h last=%b, required src=%0d dat=%h last=%b",
                                 bus.out_src_o, bus.out_data_o, bus.out_last_o, e.src, e.dat, e.lst);
                    end
                end
                n_checks++;
                if (bus.ack_o !== (4'b0001 << bus.out_src_o)) begin
                    n_errors++;
                    $display("FAIL sb_ack: got ack=%b for src=%0d", bus.ack_o, bus.out_src_o);
                end
                xfer_cnt++;
                xfer_cyc.push_back(cyc);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic check_outs(input string name, input logic busy, input logic vld, input logic [1:0] src,
                              input logic [3:0] ack, input logic lst, input logic [7:0] dat);
        chk(name, {15'd0, bus.busy_o, bus.out_valid_o, bus.out_src_o, bus.ack_o, bus.out_last_o, bus.out_data_o},
                  {15'd0, busy, vld, src, ack, lst, dat});
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input int lane, input logic [7:0] dat, input logic lst);
        exp_t e;
        e.src = 2'(lane);
        e.dat = dat;
        e.lst = lst;
        exp_q.push_back(e);
    endtask

    task automatic load_word(input int lane, input logic [7:0] dat, input logic lst);
        word_t w;
        w.dat = dat;
        w.lst = lst;
        lane_q[lane].push_back(w);
    endtask

    task automatic wait_xfers(input int target, input int budget, input string name);
        int n = 0;
        while (xfer_cnt < target && n < budget) begin
            step();
            n++;
        end
        chk(name, xfer_cnt, target);
    endtask

    function automatic vec_t mk(input logic r, input logic rdy, input int load, input logic en, input logic busy,
                                input logic vld, input logic [1:0] src, input logic [3:0] ack, input logic lst,
                                input logic [7:0] dat);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.load = load; v.en = en; v.busy = busy;
        v.vld = vld; v.src = src; v.ack = ack; v.lst = lst; v.dat = dat;
        return v;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin : main
        int base;
        bus3.req_i       = '0;
        bus3.last_i      = '0;
        bus3.data_i      = '0;
        bus3.out_ready_i = 1'b1;

        // Reset, ten idle cycles, then a four-beat burst from lane 2 and its bubble.
        tbl.push_back(mk(1, 1, -1, 0, 0, 0, 0, 4'b0000, 0, 8'h00));
        tbl.push_back(mk(1, 1, -1, 1, 0, 0, 0, 4'b0000, 0, 8'h00));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 1, -1, 1, 0, 0, 0, 4'b0000, 0, 8'h00));
        tbl.push_back(mk(0, 1,  2, 1, 0, 0, 0, 4'b0000, 0, 8'h00));
        tbl.push_back(mk(0, 1, -1, 1, 1, 1, 2, 4'b0100, 0, 8'hA0));
        tbl.push_back(mk(0, 1, -1, 1, 1, 1, 2, 4'b0100, 0, 8'hA1));
        tbl.push_back(mk(0, 1, -1, 1, 1, 1, 2, 4'b0100, 0, 8'hA2));
        tbl.push_back(mk(0, 1, -1, 1, 1, 1, 2, 4'b0100, 1, 8'hA3));
        tbl.push_back(mk(0, 1, -1, 1, 0, 0, 0, 4'b0000, 0, 8'h00));

        foreach (tbl[i]) begin
            rst_ctl = tbl[i].rst;
            rdy_ctl = tbl[i].rdy;
            if (tbl[i].load >= 0) begin
                for (int j = 0; j < 4; j++) begin
                    load_word(tbl[i].load, 8'(8'hA0 + j), (j == 3));
                    push_exp(tbl[i].load, 8'(8'hA0 + j), (j == 3));
                end
            end
            step();
            if (tbl[i].en) check_outs($sformatf("vec%0d", i), tbl[i].busy, tbl[i].vld, tbl[i].src,
                                      tbl[i].ack, tbl[i].lst, tbl[i].dat);
        end

        // ptr now points at lane 3, so lane 3 beats lane 0 when both request together.
        load_word(3, 8'hE3, 1'b1);
        load_word(0, 8'hE0, 1'b1);
        push_exp(3, 8'hE3, 1'b1);
        push_exp(0, 8'hE0, 1'b1);
        wait_xfers(xfer_cnt + 2, 20, "ptr_after_burst");
        step();
        chk("drain_ptr", exp_q.size(), 0);

        rst_ctl = 1'b1;
        step();
        rst_ctl = 1'b0;
        step();
        step();
        check_outs("idle_after_rst", 0, 0, 0, 4'b0000, 0, 8'h00);

        // All four lanes with single-beat bursts: order 0,1,2,3,0,1, one bubble between each.
        xfer_cyc.delete();
        base = xfer_cnt;
        for (int i = 0; i < 6; i++) begin
            load_word(i % 4, 8'(8'h40 + i), 1'b1);
            push_exp(i % 4, 8'(8'h40 + i), 1'b1);
        end
        wait_xfers(base + 6, 40, "rr_count");
        if (xfer_cyc.size() >= 6) begin
            for (int i = 1; i < 6; i++) chk($sformatf("rr_gap%0d", i), xfer_cyc[i] - xfer_cyc[i-1], 2);
        end
        step();
        chk("drain_rr", exp_q.size(), 0);

        // Backpressure then a request drop on lane 1.
        rdy_ctl = 1'b0;
        base = xfer_cnt;
        for (int j = 0; j < 4; j++) begin
            load_word(1, 8'(8'hB0 + j), (j == 3));
            push_exp(1, 8'(8'hB0 + j), (j == 3));
        end
        step();
        check_outs("bp_grant_cycle", 0, 0, 0, 4'b0000, 0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step();
            check_outs($sformatf("bp_stall%0d", i), 1, 1, 1, 4'b0000, 0, 8'hB0);
        end
        rdy_ctl = 1'b1;
        wait_xfers(base + 2, 20, "bp_two_beats");
        hold_ctl[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_outs($sformatf("req_drop%0d", i), 1, 0, 1, 4'b0000, 0, 8'hB2);
        end
        hold_ctl[1] = 1'b0;
        wait_xfers(base + 4, 20, "bp_burst_done");
        step();
        chk("drain_bp", exp_q.size(), 0);

        // Reset after the 2nd of 4 beats of lane 3; arbitration must restart from lane 0.
        base = xfer_cnt;
        for (int j = 0; j < 4; j++) begin
            load_word(3, 8'(8'hC0 + j), (j == 3));
            push_exp(3, 8'(8'hC0 + j), (j == 3));
        end
        wait_xfers(base + 2, 20, "mid_two_beats");
        rst_ctl = 1'b1;
        load_word(0, 8'hD0, 1'b1);
        exp_q.delete();
        push_exp(0, 8'hD0, 1'b1);
        push_exp(3, 8'hC2, 1'b0);
        push_exp(3, 8'hC3, 1'b1);
        step();
        rst_ctl = 1'b0;
        step();
        check_outs("mid_rst_idle", 0, 0, 0, 4'b0000, 0, 8'h00);
        step();
        check_outs("mid_rst_lane0", 1, 1, 0, 4'b0001, 1, 8'hD0);
        wait_xfers(base + 5, 20, "mid_rst_rest");
        step();
        chk("drain_mid", exp_q.size(), 0);

        // MAX_BEATS=3 instance: lanes 0 and 1 never assert last, grants rotate every 3 beats.
        bus3.req_i  = 4'b0011;
        bus3.last_i = 4'b0000;
        bus3.data_i = {8'h00, 8'h00, 8'h11, 8'h10};
        for (int k = 1; k <= 16; k++) begin
            int g;
            int ph;
            step();
            g  = ((k - 1) / 4) % 2;
            ph = (k - 1) % 4;
            if (k % 4 == 0) begin
                chk($sformatf("rot_idle%0d", k),
                    {bus3.busy_o, bus3.out_valid_o, bus3.out_src_o, bus3.ack_o, bus3.out_last_o},
                    9'd0);
            end else begin
                chk($sformatf("rot_beat%0d", k),
                    {bus3.busy_o, bus3.out_valid_o, bus3.out_src_o, bus3.ack_o, bus3.out_last_o, bus3.out_data_o},
                    {1'b1, 1'b1, 2'(g), 4'(4'b0001 << g), (ph == 2), 8'(8'h10 + g)});
            end
        end
        bus3.req_i = '0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
